// File: rtl/riscv_soft_host_master.sv
// riscv_soft_host_master: byte-stream command bridge issuing single word reads/writes to a tile host port
module riscv_soft_host_master #(
  parameter int XPR_LEN = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_byte,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_byte,
  input  logic               host_req_ready,
  output logic               host_req_valid,
  output logic [1:0]         host_req_op,
  output logic [2:0]         host_req_op_type,
  output logic [XPR_LEN-1:0] host_req_addr,
  output logic [XPR_LEN-1:0] host_req_data,
  input  logic               host_resp_valid,
  input  logic [XPR_LEN-1:0] host_resp_data,
  output logic               busy
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [XPR_LEN-1:0] RSP_ACK = XPR_LEN'(8'hA5);
  localparam logic [XPR_LEN-1:0] RSP_ERR = XPR_LEN'(8'hEE);
  typedef enum logic [2:0] {S_OPC, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RESP} state_t;
  state_t             r_state;
  logic [1:0]         r_cnt;
  logic [TW-1:0]      r_tmo;
  logic [2:0]         r_left;
  logic [XPR_LEN-1:0] r_rsp;
  logic [1:0]         r_op;
  logic [XPR_LEN-1:0] r_addr;
  logic [XPR_LEN-1:0] r_data;
  logic               w_cmd_fire;
  logic               w_rsp_fire;
  assign cmd_ready        = (r_state == S_OPC) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign rsp_valid        = r_state == S_RESP;
  assign rsp_byte         = r_rsp[7:0];
  assign host_req_valid   = r_state == S_REQ;
  assign host_req_op      = r_op;
  assign host_req_op_type = 3'b010;
  assign host_req_addr    = r_addr;
  assign host_req_data    = r_data;
  assign busy             = r_state != S_OPC;
  assign w_cmd_fire       = cmd_valid && cmd_ready;
  assign w_rsp_fire       = rsp_valid && rsp_ready;
  // frame parser, request issue, read wait with timeout, and response byte drain (bytes leave LSB first)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_OPC;
      r_cnt   <= 2'd0;
      r_tmo   <= '0;
      r_left  <= 3'd0;
      r_rsp   <= '0;
      r_op    <= 2'b00;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_OPC: if (w_cmd_fire) begin
          r_cnt <= 2'd0;
          if (cmd_byte == 8'h01 || cmd_byte == 8'h02) begin
            r_op    <= (cmd_byte == 8'h01) ? OP_WR : OP_RD;
            r_state <= S_ADDR;
          end else begin
            r_rsp   <= RSP_ERR;
            r_left  <= 3'd1;
            r_state <= S_RESP;
          end
        end
        S_ADDR: if (w_cmd_fire) begin
          r_addr <= {cmd_byte, r_addr[XPR_LEN-1:8]};
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= (r_op == OP_WR) ? S_DATA : S_REQ;
        end
        S_DATA: if (w_cmd_fire) begin
          r_data <= {cmd_byte, r_data[XPR_LEN-1:8]};
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= S_REQ;
        end
        S_REQ: if (host_req_ready) begin
          if (r_op == OP_WR) begin
            r_rsp   <= RSP_ACK;
            r_left  <= 3'd1;
            r_state <= S_RESP;
          end else begin
            r_tmo   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: if (host_resp_valid) begin
          r_rsp   <= host_resp_data;
          r_left  <= 3'd4;
          r_state <= S_RESP;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          r_rsp   <= RSP_ERR;
          r_left  <= 3'd1;
          r_state <= S_RESP;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
        S_RESP: if (w_rsp_fire) begin
          r_rsp  <= r_rsp >> 8;
          r_left <= r_left - 3'd1;
          if (r_left == 3'd1) r_state <= S_OPC;
        end
        default: r_state <= S_OPC;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_soft_host_master.sv
// tb_riscv_soft_host_master: table vectors, corner sequences and random frames against a frame-level model
module tb_riscv_soft_host_master;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_byte = 8'h00;
  logic        rsp_ready = 1'b0;
  logic        host_req_ready = 1'b0;
  logic        host_resp_valid = 1'b0;
  logic [31:0] host_resp_data = 32'h0;
  logic        cmd_ready, rsp_valid, host_req_valid, busy;
  logic [7:0]  rsp_byte;
  logic [1:0]  host_req_op;
  logic [2:0]  host_req_op_type;
  logic [31:0] host_req_addr, host_req_data;
  int errors = 0;
  int checks = 0;
  int req_cnt = 0;

  riscv_soft_host_master #(.XPR_LEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_byte(rsp_byte),
    .host_req_ready(host_req_ready), .host_req_valid(host_req_valid),
    .host_req_op(host_req_op), .host_req_op_type(host_req_op_type),
    .host_req_addr(host_req_addr), .host_req_data(host_req_data),
    .host_resp_valid(host_resp_valid), .host_resp_data(host_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset && host_req_valid && host_req_ready) req_cnt <= req_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  opc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdly;
    logic [1:0]  eop;
    int          en;
    logic [31:0] eb;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] wd, input bit with_addr, input bit with_data);
    send_byte(opc);
    if (with_addr) for (int i = 0; i < 4; i++) send_byte(a[8*i+:8]);
    if (with_data) for (int i = 0; i < 4; i++) send_byte(wd[8*i+:8]);
  endtask

  task automatic get_rsp(output logic [7:0] b, input int stall);
    int n = 0;
    logic [7:0] b0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", 32'(rsp_valid), 1);
    b0 = rsp_byte;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("rsp_hold_valid", 32'(rsp_valid), 1);
      chk("rsp_hold_byte", 32'(rsp_byte), 32'(b0));
    end
    b = rsp_byte;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_byte", 32'(rsp_byte), 0);
    chk("rst_req_valid", 32'(host_req_valid), 0);
    chk("rst_req_op", 32'(host_req_op), 0);
    chk("rst_req_op_type", 32'(host_req_op_type), 2);
    chk("rst_req_addr", host_req_addr, 0);
    chk("rst_req_data", host_req_data, 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  function automatic void model(input logic [7:0] opc, input logic [31:0] rd, input bit tmo,
                                output logic [1:0] op, output int n, output logic [31:0] eb);
    op = (opc == 8'h01) ? 2'b10 : (opc == 8'h02) ? 2'b01 : 2'b00;
    n  = (op == 2'b01 && !tmo) ? 4 : 1;
    eb = (op == 2'b10) ? 32'hA5 : (n == 4) ? rd : 32'hEE;
  endfunction

  task automatic run_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input bit tmo, input int rdly, input int rsdly,
                           input logic [1:0] eop, input int en, input logic [31:0] eb);
    int base;
    int n = 0;
    logic [7:0] b;
    base = req_cnt;
    send_frame(opc, a, wd, eop != 2'b00, eop == 2'b10);
    if (eop != 2'b00) begin
      @(negedge clk);
      while (!host_req_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      for (int k = 0; k <= rdly; k++) begin
        chk("req_valid", 32'(host_req_valid), 1);
        chk("req_op", 32'(host_req_op), 32'(eop));
        chk("req_op_type", 32'(host_req_op_type), 2);
        chk("req_addr", host_req_addr, a);
        if (eop == 2'b10) chk("req_data", host_req_data, wd);
        if (k < rdly) @(negedge clk);
      end
      @(posedge clk);
      #1 host_req_ready = 1'b1;
      @(posedge clk);
      #1 host_req_ready = 1'b0;
      if (eop == 2'b01 && !tmo) begin
        repeat (rsdly) @(posedge clk);
        #1 host_resp_valid = 1'b1;
        host_resp_data = rd;
        @(posedge clk);
        #1 host_resp_valid = 1'b0;
        host_resp_data = $urandom;
      end
    end
    for (int i = 0; i < en; i++) begin
      get_rsp(b, $urandom_range(0, 2));
      chk("rsp_byte", 32'(b), 32'(eb[8*i+:8]));
    end
    chk("end_busy", 32'(busy), 0);
    chk("end_rsp_valid", 32'(rsp_valid), 0);
    chk("req_count", 32'(req_cnt - base), (eop != 2'b00) ? 1 : 0);
  endtask

  initial begin
    logic [7:0]  b;
    int          base;
    logic [7:0]  r_opc;
    logic [31:0] r_a, r_wd, r_rd, r_eb;
    bit          r_tmo;
    logic [1:0]  r_eop;
    int          r_en;
    int          r_sel;
    vt[0] = '{8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 2'b10, 1, 32'hA5};
    vt[1] = '{8'h02, 32'h0000_0010, 32'h0,         32'h1234_5678, 0, 2'b01, 4, 32'h1234_5678};
    vt[2] = '{8'h01, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,         5, 2'b10, 1, 32'hA5};
    vt[3] = '{8'h02, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 2, 2'b01, 4, 32'hFFFF_FFFF};
    vt[4] = '{8'h00, 32'h0,         32'h0,         32'h0,         0, 2'b00, 1, 32'hEE};
    vt[5] = '{8'hFF, 32'h0,         32'h0,         32'h0,         0, 2'b00, 1, 32'hEE};
    vt[6] = '{8'h01, 32'h8000_0000, 32'h0000_0001, 32'h0,         1, 2'b10, 1, 32'hA5};

    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // write frame with minimum latency: request right after last byte, ack the cycle after acceptance
    base = req_cnt;
    host_req_ready = 1'b1;
    send_frame(8'h01, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("lat_wr_req_valid", 32'(host_req_valid), 1);
    chk("lat_wr_op", 32'(host_req_op), 2);
    chk("lat_wr_addr", host_req_addr, 32'h10);
    chk("lat_wr_data", host_req_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 host_req_ready = 1'b0;
    chk("lat_wr_rsp_valid", 32'(rsp_valid), 1);
    chk("lat_wr_rsp_byte", 32'(rsp_byte), 32'hA5);
    get_rsp(b, 0);
    chk("lat_wr_ack", 32'(b), 32'hA5);
    chk("lat_wr_req_count", 32'(req_cnt - base), 1);

    // read frame, tile answers 3 cycles after accept, LSB byte offered the next cycle
    host_req_ready = 1'b1;
    send_frame(8'h02, 32'h10, 32'h0, 1'b1, 1'b0);
    chk("lat_rd_req_valid", 32'(host_req_valid), 1);
    chk("lat_rd_op", 32'(host_req_op), 1);
    @(posedge clk);
    #1 host_req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 host_resp_valid = 1'b1;
    host_resp_data = 32'h1234_5678;
    @(posedge clk);
    #1 host_resp_valid = 1'b0;
    host_resp_data = 32'h0;
    chk("lat_rd_rsp_valid", 32'(rsp_valid), 1);
    chk("lat_rd_rsp_lsb", 32'(rsp_byte), 32'h78);
    for (int i = 0; i < 4; i++) begin
      get_rsp(b, 0);
      chk("lat_rd_bytes", 32'(b), 32'(8'h78 - 8'h22 * i));
    end

    // read with no tile answer: error byte after 16 wait cycles, late answer ignored
    base = req_cnt;
    host_req_ready = 1'b1;
    send_frame(8'h02, 32'h44, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1 host_req_ready = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1 chk("tmo_wait_rsp_valid", 32'(rsp_valid), 0);
      chk("tmo_wait_cmd_ready", 32'(cmd_ready), 0);
      chk("tmo_wait_busy", 32'(busy), 1);
    end
    @(posedge clk);
    #1 chk("tmo_rsp_valid", 32'(rsp_valid), 1);
    chk("tmo_rsp_byte", 32'(rsp_byte), 32'hEE);
    host_resp_valid = 1'b1;
    host_resp_data  = 32'h55AA_55AA;
    @(posedge clk);
    #1 host_resp_valid = 1'b0;
    chk("tmo_late_ignored", 32'(rsp_byte), 32'hEE);
    get_rsp(b, 0);
    chk("tmo_err_byte", 32'(b), 32'hEE);
    repeat (3) begin
      @(negedge clk);
      chk("tmo_no_extra_rsp", 32'(rsp_valid), 0);
    end
    chk("tmo_req_count", 32'(req_cnt - base), 1);

    // unknown opcode with a stalled consumer
    base = req_cnt;
    send_byte(8'h7F);
    get_rsp(b, 3);
    chk("bad_opc_byte", 32'(b), 32'hEE);
    chk("bad_opc_no_req", 32'(req_cnt - base), 0);

    // reset in the middle of the address bytes aborts the frame
    send_byte(8'h02);
    for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i));
    @(negedge clk);
    reset = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    base = req_cnt;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_req", 32'(host_req_valid), 0);
      chk("abort_no_rsp", 32'(rsp_valid), 0);
    end
    chk("abort_req_count", 32'(req_cnt - base), 0);
    run_frame(8'h02, 32'h0000_0100, 32'h0, 32'hA1B2_C3D4, 1'b0, 1, 2, 2'b01, 4, 32'hA1B2_C3D4);

    for (int t = 0; t < 7; t++)
      run_frame(vt[t].opc, vt[t].addr, vt[t].wdata, vt[t].rdata, 1'b0, vt[t].rdly, t % 4,
                vt[t].eop, vt[t].en, vt[t].eb);

    for (int t = 0; t < 40; t++) begin
      r_sel = $urandom_range(0, 9);
      r_opc = (r_sel < 4) ? 8'h01 : (r_sel < 8) ? 8'h02 : 8'($urandom_range(3, 255));
      r_a   = $urandom;
      r_wd  = $urandom;
      r_rd  = $urandom;
      r_tmo = ($urandom_range(0, 4) == 0);
      model(r_opc, r_rd, r_tmo, r_eop, r_en, r_eb);
      run_frame(r_opc, r_a, r_wd, r_rd, r_tmo, $urandom_range(0, 3), $urandom_range(0, 5), r_eop, r_en, r_eb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
